// File: rtl/mca_pkg.sv
// mca_pkg: shared FSM state type and saturation limits for multichannel_accum
package mca_pkg;

   typedef enum logic {ACCUM, DRAIN} state_t;

   // Largest value representable in a w-bit two's-complement word
   function automatic logic signed [63:0] sat_max(input int w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   // Smallest value representable in a w-bit two's-complement word
   function automatic logic signed [63:0] sat_min(input int w);
      return -(64'sd1 <<< (w - 1));
   endfunction

endpackage

// File: rtl/mca_sat_add.sv
// mca_sat_add: AW-bit signed adder, clamps when MULTICHANNEL_ACCUM_SAT_EN is defined, wraps otherwise
module mca_sat_add #(
   parameter int AW = 24
) (
   input  logic signed [AW-1:0] a,
   input  logic signed [AW-1:0] b,
   output logic signed [AW-1:0] sum
);

`ifdef MULTICHANNEL_ACCUM_SAT_EN
   localparam logic signed [AW-1:0] SMAX = AW'(mca_pkg::sat_max(AW));
   localparam logic signed [AW-1:0] SMIN = AW'(mca_pkg::sat_min(AW));
   logic signed [AW:0] wide;
   assign wide = {a[AW-1], a} + {b[AW-1], b};
   // A carry that disagrees with the sign bit means the true sum left the AW-bit range
   assign sum = (wide[AW] != wide[AW-1]) ? (wide[AW] ? SMIN : SMAX) : wide[AW-1:0];
`else
   assign sum = a + b;
`endif

endmodule

// File: rtl/multichannel_accum.sv
// multichannel_accum: per-channel signed accumulators drained in channel order after a last beat (MULTICHANNEL_ACCUM_SAT_EN selects saturating adds)
module multichannel_accum
   import mca_pkg::*;
#(
   parameter int DW  = 16,
   parameter int AW  = 24,
   parameter int NCH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [$clog2(NCH)-1:0]  in_ch,
   input  logic signed [DW-1:0]    in_data,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [$clog2(NCH)-1:0]  out_ch,
   output logic signed [AW-1:0]    out_data,
   output logic                    ch_err
);

   localparam int CW = $clog2(NCH);

   state_t                 state;
   logic signed [AW-1:0]   acc [NCH];
   logic [CW-1:0]          idx;
   logic [CW-1:0]          rd;
   logic                   accept;
   logic                   ch_ok;
   logic                   xfer;
   logic                   last_idx;
   logic signed [AW-1:0]   ext;
   logic signed [AW-1:0]   sum;

   assign accept   = in_valid && in_ready;
   assign ch_ok    = 32'(in_ch) < NCH;
   assign xfer     = out_valid && out_ready;
   assign last_idx = 32'(idx) == NCH - 1;
   assign rd       = ch_ok ? in_ch : '0;
   assign ext      = AW'(in_data);
   assign out_ch   = idx;
   assign out_data = out_valid ? acc[idx] : '0;

   mca_sat_add #(.AW(AW)) u_add (
      .a   (acc[rd]),
      .b   (ext),
      .sum (sum)
   );

   // Window control: accumulate until a last beat, then hand out every channel once
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ACCUM;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         idx       <= '0;
         ch_err    <= 1'b0;
      end else if (state == ACCUM) begin
         if (accept && !ch_ok) ch_err <= 1'b1;
         if (accept && in_last) begin
            state     <= DRAIN;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
            idx       <= '0;
         end
      end else if (xfer) begin
         if (last_idx) begin
            state     <= ACCUM;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            idx       <= '0;
         end else begin
            idx <= idx + 1'b1;
         end
      end
   end

   // Accumulators: add on an in-range beat, clear once the channel has been handed off
   always_ff @(posedge clk) begin
      for (int i = 0; i < NCH; i++) begin
         if (rst) acc[i] <= '0;
         else if (accept && ch_ok && 32'(in_ch) == i) acc[i] <= sum;
         else if (xfer && 32'(idx) == i) acc[i] <= '0;
      end
   end

endmodule

// File: tb/tb_multichannel_accum.sv
// tb_multichannel_accum: directed checks of accumulate, drain, stall, error, saturation and reset behaviour
module tb_multichannel_accum;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   logic               a_in_valid = 1'b0, a_in_ready, a_in_last = 1'b0, a_out_valid, a_out_ready = 1'b0, a_ch_err;
   logic [1:0]         a_in_ch = '0, a_out_ch;
   logic signed [15:0] a_in_data = '0;
   logic signed [23:0] a_out_data;

   logic               b_in_valid = 1'b0, b_in_ready, b_in_last = 1'b0, b_out_valid, b_out_ready = 1'b0, b_ch_err;
   logic [2:0]         b_in_ch = '0, b_out_ch;
   logic signed [15:0] b_in_data = '0;
   logic signed [23:0] b_out_data;

   logic               c_in_valid = 1'b0, c_in_ready, c_in_last = 1'b0, c_out_valid, c_out_ready = 1'b0, c_ch_err;
   logic [1:0]         c_in_ch = '0, c_out_ch;
   logic signed [7:0]  c_in_data = '0;
   logic signed [7:0]  c_out_data;

   multichannel_accum #(.DW(16), .AW(24), .NCH(4)) dut_a (
      .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ch(a_in_ch),
      .in_data(a_in_data), .in_last(a_in_last), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_ch(a_out_ch), .out_data(a_out_data), .ch_err(a_ch_err));

   multichannel_accum #(.DW(16), .AW(24), .NCH(6)) dut_b (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ch(b_in_ch),
      .in_data(b_in_data), .in_last(b_in_last), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_ch(b_out_ch), .out_data(b_out_data), .ch_err(b_ch_err));

   multichannel_accum #(.DW(8), .AW(8), .NCH(4)) dut_c (
      .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_ch(c_in_ch),
      .in_data(c_in_data), .in_last(c_in_last), .out_valid(c_out_valid), .out_ready(c_out_ready),
      .out_ch(c_out_ch), .out_data(c_out_data), .ch_err(c_ch_err));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat_a(input int ch, input int data, input logic last);
      a_in_valid = 1'b1; a_in_ch = 2'(ch); a_in_data = 16'(data); a_in_last = last;
      tick();
      a_in_valid = 1'b0; a_in_last = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      total += 6;
      if (a_in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", a_in_ready); end
      if (a_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", a_out_valid); end
      if (a_out_ch !== 2'd0) begin bad++; $display("FAIL reset_out_ch got=%0d want=0", a_out_ch); end
      if (a_out_data !== 24'sd0) begin bad++; $display("FAIL reset_out_data got=%0d want=0", a_out_data); end
      if (a_ch_err !== 1'b0) begin bad++; $display("FAIL reset_ch_err got=%b want=0", a_ch_err); end
      if (b_ch_err !== 1'b0) begin bad++; $display("FAIL reset_b_ch_err got=%b want=0", b_ch_err); end
   endtask

   task automatic test_basic();
      int e [4] = '{7, -3, 0, 7};
      beat_a(0, 5, 1'b0);
      beat_a(1, -3, 1'b0);
      beat_a(0, 2, 1'b0);
      beat_a(3, 7, 1'b1);
      a_out_ready = 1'b1;
      total += 2;
      if (a_out_valid !== 1'b1) begin bad++; $display("FAIL basic_latency got=%b want=1", a_out_valid); end
      if (a_in_ready !== 1'b0) begin bad++; $display("FAIL basic_in_ready_drain got=%b want=0", a_in_ready); end
      for (int i = 0; i < 4; i++) begin
         total += 2;
         if (a_out_ch !== 2'(i)) begin bad++; $display("FAIL basic_ch got=%0d want=%0d", a_out_ch, i); end
         if (a_out_data !== 24'(e[i])) begin bad++; $display("FAIL basic_data ch=%0d got=%0d want=%0d", i, a_out_data, e[i]); end
         tick();
      end
      total += 2;
      if (a_in_ready !== 1'b1) begin bad++; $display("FAIL basic_return got=%b want=1", a_in_ready); end
      if (a_out_valid !== 1'b0) begin bad++; $display("FAIL basic_done got=%b want=0", a_out_valid); end
      a_out_ready = 1'b0;
   endtask

   task automatic test_stall();
      int e [4] = '{0, 10, 1, 0};
      beat_a(1, 10, 1'b0);
      beat_a(2, 1, 1'b1);
      a_out_ready = 1'b1;
      total += 2;
      if (a_out_ch !== 2'd0) begin bad++; $display("FAIL stall_first_ch got=%0d want=0", a_out_ch); end
      if (a_out_data !== 24'sd0) begin bad++; $display("FAIL stall_first_data got=%0d want=0", a_out_data); end
      tick();
      a_out_ready = 1'b0;
      a_in_valid = 1'b1; a_in_ch = 2'd3; a_in_data = 16'sd50;
      for (int k = 0; k < 3; k++) begin
         tick();
         total += 4;
         if (a_out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid got=%b want=1", a_out_valid); end
         if (a_in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%b want=0", a_in_ready); end
         if (a_out_ch !== 2'd1) begin bad++; $display("FAIL stall_ch got=%0d want=1", a_out_ch); end
         if (a_out_data !== 24'sd10) begin bad++; $display("FAIL stall_data got=%0d want=10", a_out_data); end
      end
      a_in_valid = 1'b0;
      a_out_ready = 1'b1;
      for (int i = 1; i < 4; i++) begin
         total += 2;
         if (a_out_ch !== 2'(i)) begin bad++; $display("FAIL stall_rest_ch got=%0d want=%0d", a_out_ch, i); end
         if (a_out_data !== 24'(e[i])) begin bad++; $display("FAIL stall_rest_data ch=%0d got=%0d want=%0d", i, a_out_data, e[i]); end
         tick();
      end
      total++;
      if (a_in_ready !== 1'b1) begin bad++; $display("FAIL stall_return got=%b want=1", a_in_ready); end
      a_out_ready = 1'b0;
   endtask

   task automatic test_rst_mid();
      int e [4] = '{0, 0, 1, 0};
      beat_a(0, 3, 1'b0);
      beat_a(1, 4, 1'b0);
      beat_a(2, 5, 1'b0);
      beat_a(3, 6, 1'b1);
      a_out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         total++;
         if (a_out_data !== 24'(i + 3)) begin bad++; $display("FAIL rstmid_pre ch=%0d got=%0d want=%0d", i, a_out_data, i + 3); end
         tick();
      end
      rst = 1'b1;
      a_in_valid = 1'b1; a_in_ch = 2'd2; a_in_data = 16'sd100;
      tick();
      rst = 1'b0;
      a_in_valid = 1'b0;
      total += 3;
      if (a_out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b want=0", a_out_valid); end
      if (a_in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready got=%b want=1", a_in_ready); end
      if (a_out_ch !== 2'd0) begin bad++; $display("FAIL rstmid_out_ch got=%0d want=0", a_out_ch); end
      beat_a(2, 1, 1'b1);
      for (int i = 0; i < 4; i++) begin
         total += 2;
         if (a_out_ch !== 2'(i)) begin bad++; $display("FAIL rstmid_ch got=%0d want=%0d", a_out_ch, i); end
         if (a_out_data !== 24'(e[i])) begin bad++; $display("FAIL rstmid_data ch=%0d got=%0d want=%0d", i, a_out_data, e[i]); end
         tick();
      end
      a_out_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      int e1 [4] = '{1, 2, 0, 0};
      int e2 [4] = '{10, 20, 0, 0};
      beat_a(0, 1, 1'b0);
      beat_a(1, 2, 1'b1);
      a_in_valid = 1'b1; a_in_ch = 2'd0; a_in_data = 16'sd10; a_in_last = 1'b0;
      a_out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (a_out_data !== 24'(e1[i])) begin bad++; $display("FAIL b2b_w1 ch=%0d got=%0d want=%0d", i, a_out_data, e1[i]); end
         tick();
      end
      total++;
      if (a_in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b want=1", a_in_ready); end
      tick();
      a_in_ch = 2'd1; a_in_data = 16'sd20; a_in_last = 1'b1;
      tick();
      a_in_valid = 1'b0; a_in_last = 1'b0;
      for (int i = 0; i < 4; i++) begin
         total += 2;
         if (a_out_valid !== 1'b1) begin bad++; $display("FAIL b2b_w2_valid got=%b want=1", a_out_valid); end
         if (a_out_data !== 24'(e2[i])) begin bad++; $display("FAIL b2b_w2 ch=%0d got=%0d want=%0d", i, a_out_data, e2[i]); end
         tick();
      end
      a_out_ready = 1'b0;
   endtask

   task automatic test_ch_err();
      b_in_valid = 1'b1; b_in_ch = 3'd7; b_in_data = 16'sd9; b_in_last = 1'b1;
      tick();
      b_in_valid = 1'b0; b_in_last = 1'b0;
      b_out_ready = 1'b1;
      total += 2;
      if (b_ch_err !== 1'b1) begin bad++; $display("FAIL err_set got=%b want=1", b_ch_err); end
      if (b_out_valid !== 1'b1) begin bad++; $display("FAIL err_drain got=%b want=1", b_out_valid); end
      for (int i = 0; i < 6; i++) begin
         total += 2;
         if (b_out_ch !== 3'(i)) begin bad++; $display("FAIL err_ch got=%0d want=%0d", b_out_ch, i); end
         if (b_out_data !== 24'sd0) begin bad++; $display("FAIL err_data ch=%0d got=%0d want=0", i, b_out_data); end
         tick();
      end
      total += 2;
      if (b_ch_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", b_ch_err); end
      if (b_in_ready !== 1'b1) begin bad++; $display("FAIL err_return got=%b want=1", b_in_ready); end
      b_out_ready = 1'b0;
   endtask

   task automatic test_sat();
`ifdef MULTICHANNEL_ACCUM_SAT_EN
      int e [4] = '{127, 0, 0, 0};
`else
      int e [4] = '{-56, 0, 0, 0};
`endif
      c_in_valid = 1'b1; c_in_ch = 2'd0; c_in_data = 8'sd100; c_in_last = 1'b0;
      tick();
      c_in_last = 1'b1;
      tick();
      c_in_valid = 1'b0; c_in_last = 1'b0;
      c_out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (c_out_data !== 8'(e[i])) begin bad++; $display("FAIL sat_data ch=%0d got=%0d want=%0d", i, c_out_data, e[i]); end
         tick();
      end
      c_out_ready = 1'b0;
   endtask

   initial begin
      #1;
      test_reset();
      test_basic();
      test_stall();
      test_ch_err();
      test_sat();
      test_back_to_back();
      test_rst_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multichannel_accum.md
MULTICHANNEL_ACCUM -- requirements
Module: multichannel_accum

Interface
REQ-001 SHALL have parameter DW, default 16, signed input sample width.
REQ-002 SHALL have parameter AW, default 24, signed accumulator and output width; AW >= DW.
REQ-003 SHALL have parameter NCH, default 8, channel count, >= 2.
REQ-004 SHALL have clk, input, 1, clock.
REQ-005 SHALL have rst, input, 1, reset (synchronous, active-high).
REQ-006 SHALL have in_valid, input, 1, input beat present.
REQ-007 SHALL have in_ready, output, 1, block accepts input beat.
REQ-008 SHALL have in_ch, input, $clog2(NCH), channel tag of the beat.
REQ-009 SHALL have in_data, input, DW, signed sample.
REQ-010 SHALL have in_last, input, 1, final beat of the accumulation window.
REQ-011 SHALL have out_valid, output, 1, result present.
REQ-012 SHALL have out_ready, input, 1, downstream accepts result.
REQ-013 SHALL have out_ch, output, $clog2(NCH), channel index of the result.
REQ-014 SHALL have out_data, output, AW, signed accumulated result.
REQ-015 SHALL have ch_err, output, 1, sticky out-of-range channel flag.

Function
REQ-016 SHALL hold one AW-bit signed accumulator per channel and use a two-state FSM, ACCUM and DRAIN.
REQ-017 In ACCUM, in_ready SHALL be 1 and out_valid 0; a beat is accepted when in_valid && in_ready.
REQ-018 An accepted beat SHALL update acc[in_ch] with acc + sign-extended in_data, visible the next cycle.
REQ-019 A beat with in_ch >= NCH SHALL be accepted, leave every accumulator unchanged, and set ch_err.
REQ-020 An accepted beat with in_last=1 SHALL apply its data and then move the FSM to DRAIN on the next cycle, also when in_ch is out of range.
REQ-021 In DRAIN, in_ready SHALL be 0 and out_valid 1, and out_ch/out_data SHALL present channels 0..NCH-1 in ascending order.
REQ-022 out_ch/out_data SHALL stay stable while out_valid && !out_ready.
REQ-023 On each out_valid && out_ready transfer, the emitted accumulator SHALL be cleared to 0 and the index SHALL advance.
REQ-024 The transfer of channel NCH-1 SHALL return the FSM to ACCUM, with in_ready=1 on the following cycle.
REQ-025 Latency SHALL be 1 cycle from acceptance of the in_last beat to the first out_valid; drain SHALL take NCH cycles when out_ready is held at 1.
REQ-026 ch_err SHALL clear only on rst.

Reset
REQ-027 rst SHALL clear all accumulators, the drain index and ch_err, and force state ACCUM, in_ready=1, out_valid=0, out_ch=0 and out_data=0.
REQ-028 rst asserted mid-DRAIN SHALL abort the drain with no further out_valid, and any pending beat SHALL be ignored.

Configuration
REQ-029 With macro MULTICHANNEL_ACCUM_SAT_EN defined, each add SHALL saturate to the AW-bit signed range, +(2^(AW-1))-1 and -2^(AW-1).
REQ-030 Without MULTICHANNEL_ACCUM_SAT_EN, each add SHALL wrap modulo 2^AW.

Structure
REQ-031 Shared package mca_pkg SHALL hold the FSM state typedef (ACCUM, DRAIN) and the saturation-limit constant functions.
REQ-032 The adder SHALL be a single sub-module, mca_sat_add (AW-bit signed add with optional clamp), instanced once and shared by all channels.

Verification
REQ-033 Bench SHALL cover: NCH=4, beats ch0:+5, ch1:-3, ch0:+2, ch3:+7 with last -> drain outputs (0,7), (1,-3), (2,0), (3,7), then in_ready=1.
REQ-034 Bench SHALL cover: during drain, out_ready low for 3 cycles on ch1 -> out_ch=1 and out_data held stable, no beat accepted, drain completes after release.
REQ-035 Bench SHALL cover: AW=8, SAT_EN defined, ch0 receives +100 twice -> out_data=127; SAT_EN undefined -> out_data=-56.
REQ-036 Bench SHALL cover: NCH=6, beat in_ch=7 data 9 with last -> ch_err=1, all six outputs 0, ch_err still 1 after drain.
REQ-037 Bench SHALL cover: rst pulsed after 2 of 4 drain transfers -> out_valid=0 the next cycle, new window from ch2:+1 with last drains (2,1) and zeros elsewhere.
REQ-038 Bench SHALL cover: back-to-back windows with in_valid held at 1 -> second window sums exclude first window data.
